// File: rtl/load_store_sched_if.sv
// Load/store scheduler bus: requester levels in, grants, volume and status out.
interface load_store_sched_if #(
  parameter int unsigned CBITS = 14
);
  logic             ld_req;
  logic             st_req;
  logic             ld_gnt;
  logic             st_gnt;
  logic [CBITS-1:0] vol;
  logic             full;
  logic             empty;
  logic             xfer_done;

  modport master (
    output ld_req, st_req,
    input  ld_gnt, st_gnt, vol, full, empty, xfer_done
  );

  modport slave (
    input  ld_req, st_req,
    output ld_gnt, st_gnt, vol, full, empty, xfer_done
  );
endinterface

// File: rtl/load_store_sched.sv
// Round-robin burst scheduler sharing one saturating volume counter between
// a load (fill) requester and a store (drain) requester.
module load_store_sched #(
  parameter int unsigned N     = 12500,
  parameter int unsigned CBITS = 14,
  parameter int unsigned BURST = 16
) (
  input logic               clk,
  input logic               rst,
  load_store_sched_if.slave bus
);
  localparam int unsigned BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CBITS-1:0] vol_q, vol_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             rr_last_q, rr_last_d;  // 1: last grant went to STORE
  logic             ld_gnt_q, ld_gnt_d;
  logic             st_gnt_q, st_gnt_d;
  logic             xfer_done_q, xfer_done_d;
  logic             full_c, empty_c, ld_ok_c, st_ok_c, last_beat_c;

  assign full_c      = (vol_q == CBITS'(N));
  assign empty_c     = (vol_q == '0);
  assign ld_ok_c     = bus.ld_req && !full_c;
  assign st_ok_c     = bus.st_req && !empty_c;
  assign last_beat_c = (beat_q == BW'(BURST - 1));

  // Next-state, counter and pulse logic
  always_comb begin
    state_d     = state_q;
    vol_d       = vol_q;
    beat_d      = beat_q;
    rr_last_d   = rr_last_q;
    xfer_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_ok_c && (!st_ok_c || rr_last_q)) begin
          state_d   = S_LOAD;
          rr_last_d = 1'b0;
          beat_d    = '0;
        end else if (st_ok_c) begin
          state_d   = S_STORE;
          rr_last_d = 1'b1;
          beat_d    = '0;
        end
      end
      S_LOAD: begin
        if (!bus.ld_req) begin
          state_d     = S_IDLE;
          xfer_done_d = 1'b1;
        end else begin
          if (!full_c) vol_d = vol_q + CBITS'(1);
          beat_d = beat_q + BW'(1);
          if (last_beat_c || full_c || vol_q == CBITS'(N - 1)) begin
            state_d     = S_IDLE;
            xfer_done_d = 1'b1;
          end
        end
      end
      S_STORE: begin
        if (!bus.st_req) begin
          state_d     = S_IDLE;
          xfer_done_d = 1'b1;
        end else begin
          if (!empty_c) vol_d = vol_q - CBITS'(1);
          beat_d = beat_q + BW'(1);
          if (last_beat_c || empty_c || vol_q == CBITS'(1)) begin
            state_d     = S_IDLE;
            xfer_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ld_gnt_d = (state_d == S_LOAD);
    st_gnt_d = (state_d == S_STORE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      vol_q       <= '0;
      beat_q      <= '0;
      rr_last_q   <= 1'b1;
      ld_gnt_q    <= 1'b0;
      st_gnt_q    <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vol_q       <= vol_d;
      beat_q      <= beat_d;
      rr_last_q   <= rr_last_d;
      ld_gnt_q    <= ld_gnt_d;
      st_gnt_q    <= st_gnt_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  assign bus.ld_gnt    = ld_gnt_q;
  assign bus.st_gnt    = st_gnt_q;
  assign bus.vol       = vol_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.xfer_done = xfer_done_q;
endmodule

// File: tb/tb_load_store_sched.sv
// Scoreboard bench for load_store_sched: burst-level reference model feeds an
// expectation queue that a monitor drains one entry per clock.
module tb_load_store_sched;
  localparam int unsigned N     = 20;
  localparam int unsigned CBITS = 5;
  localparam int unsigned BURST = 4;

  typedef struct packed {
    logic             ld_gnt;
    logic             st_gnt;
    logic [CBITS-1:0] vol;
    logic             full;
    logic             empty;
    logic             xfer_done;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_sched_if #(.CBITS(CBITS)) bus ();

  load_store_sched #(.N(N), .CBITS(CBITS), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   fails  = 0;
  obs_t exp_q[$];

  // Reference model: a burst is a direction (+1 load, -1 store, 0 none) and a beat count.
  int m_vol;
  int m_dir;
  int m_beats;
  bit m_last_store;

  task automatic model_reset();
    m_vol = 0; m_dir = 0; m_beats = 0; m_last_store = 1'b1;
  endtask

  // Drive requests for the next rising edge and queue what that edge must produce.
  task automatic step(input bit ld, input bit st);
    obs_t e;
    bit   xd;
    bit   ld_ok, st_ok, req;
    @(negedge clk);
    bus.ld_req = ld;
    bus.st_req = st;
    xd = 1'b0;
    if (m_dir == 0) begin
      ld_ok = ld && (m_vol < N);
      st_ok = st && (m_vol > 0);
      if (ld_ok && st_ok) m_dir = m_last_store ? 1 : -1;
      else if (ld_ok)     m_dir = 1;
      else if (st_ok)     m_dir = -1;
      if (m_dir != 0) begin
        m_beats      = 0;
        m_last_store = (m_dir < 0);
      end
    end else begin
      req = (m_dir > 0) ? ld : st;
      if (!req) begin
        m_dir = 0;
        xd    = 1'b1;
      end else begin
        m_vol   = m_vol + m_dir;
        m_beats = m_beats + 1;
        if (m_beats == BURST || m_vol == N || m_vol == 0) begin
          m_dir = 0;
          xd    = 1'b1;
        end
      end
    end
    e.ld_gnt    = (m_dir > 0);
    e.st_gnt    = (m_dir < 0);
    e.vol       = CBITS'(m_vol);
    e.full      = (m_vol == N);
    e.empty     = (m_vol == 0);
    e.xfer_done = xd;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every DUT cycle that has a queued expectation.
  always @(posedge clk) begin
    obs_t e;
    obs_t g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bus.ld_gnt, bus.st_gnt, bus.vol, bus.full, bus.empty, bus.xfer_done};
      checks++;
      if (g !== e) begin
        fails++;
        $display("FAIL scoreboard @%0t: got ld_gnt=%b st_gnt=%b vol=%0d full=%b empty=%b xfer_done=%b, expected ld_gnt=%b st_gnt=%b vol=%0d full=%b empty=%b xfer_done=%b",
                 $time, g.ld_gnt, g.st_gnt, g.vol, g.full, g.empty, g.xfer_done,
                 e.ld_gnt, e.st_gnt, e.vol, e.full, e.empty, e.xfer_done);
      end
      checks++;
      if (bus.ld_gnt && bus.st_gnt) begin
        fails++;
        $display("FAIL gnt_exclusive @%0t: got both grants high, expected at most one", $time);
      end
    end
  end

  initial begin
    bit l, s;
    bus.ld_req = 1'b0;
    bus.st_req = 1'b0;
    model_reset();
    #12;
    check("reset_vol", int'(bus.vol), 0);
    check("reset_empty", int'(bus.empty), 1);
    check("reset_full", int'(bus.full), 0);
    check("reset_gnt", int'({bus.ld_gnt, bus.st_gnt}), 0);
    check("reset_xfer_done", int'(bus.xfer_done), 0);
    @(negedge clk);
    rst = 1'b1;

    // Idle, then fill to saturation and sit there
    repeat (5) step(1'b0, 1'b0);
    repeat (32) step(1'b1, 1'b0);
    drain();
    check("sat_vol", int'(bus.vol), 20);
    check("sat_full", int'(bus.full), 1);
    check("sat_no_ld_gnt", int'(bus.ld_gnt), 0);

    // Drain to 8, then alternate with both requesting
    repeat (15) step(1'b0, 1'b1);
    drain();
    check("vol_8", int'(bus.vol), 8);
    step(1'b1, 1'b1);
    drain();
    check("tie_first_load", int'(bus.ld_gnt), 1);
    repeat (19) step(1'b1, 1'b1);
    drain();
    check("alt_vol", int'(bus.vol), 8);

    // Empty, then a load dropped after two beats, then store hits zero early
    repeat (10) step(1'b0, 1'b1);
    drain();
    check("empty_flag", int'(bus.empty), 1);
    repeat (3) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    drain();
    check("drop_vol", int'(bus.vol), 2);
    repeat (6) step(1'b0, 1'b1);
    drain();
    check("store_to_zero", int'(bus.vol), 0);
    check("store_ignored_empty", int'(bus.st_gnt), 0);

    // Asynchronous reset in the middle of a store burst
    repeat (10) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    drain();
    check("mid_store_gnt", int'(bus.st_gnt), 1);
    rst = 1'b0;
    bus.ld_req = 1'b0;
    bus.st_req = 1'b0;
    #1;
    check("async_rst_vol", int'(bus.vol), 0);
    check("async_rst_gnt", int'({bus.ld_gnt, bus.st_gnt}), 0);
    check("async_rst_empty", int'(bus.empty), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized sticky requests
    l = 1'b0;
    s = 1'b0;
    repeat (3000) begin
      if ($urandom_range(7) == 0) l = ~l;
      if ($urandom_range(7) == 0) s = ~s;
      step(l, s);
    end
    drain();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
